// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
// State encoding plus channel count / select width for the 3:8 decoder.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

endpackage

// File: rtl/scan_seq_if.sv
// Control and decoder-drive bundle between a scan controller and scan_seq.
// master = controller side, slave = sequencer side.
interface scan_seq_if;
    import scan_pkg::*;

    logic             start;
    logic             stop;
    logic             mode;
    logic             hold;
    logic [SEL_W-1:0] a;
    logic             enable;
    logic             busy;
    logic             step;
    logic             done;

    modport master (
        output start, stop, mode, hold,
        input  a, enable, busy, step, done
    );

    modport slave (
        input  start, stop, mode, hold,
        output a, enable, busy, step, done
    );

endinterface

// File: rtl/dwell_timer.sv
// 8-bit dwell counter: counts enabled cycles 0..DWELL-1 and wraps.
// expire is high whenever the count sits on its last value; clr wins over en.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= expire ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign expire = (r_cnt == LAST);

endmodule

// File: rtl/scan_seq.sv
// Steps a 3:8 decoder select through all channels, DWELL cycles each, single-pass or continuous.
// All outputs registered; stop aborts to IDLE, hold freezes channel and dwell count.
module scan_seq
    import scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    scan_seq_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_a;
    logic [SEL_W-1:0] w_a_nxt;
    logic             r_enable, w_enable_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_step,   w_step_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_mode,   w_mode_nxt;

    logic w_expire;
    logic w_clr;
    logic w_cnt_en;
    logic w_advance;

    // Counter is held at zero outside SCAN so every scan starts with a fresh dwell.
    assign w_clr     = (r_state != SCAN) || bus.stop;
    assign w_cnt_en  = (r_state == SCAN) && !bus.hold && !bus.stop;
    assign w_advance = w_expire && !bus.hold;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_cnt_en),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
            r_mode   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= w_busy_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
            r_mode   <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (w_advance && (r_a == LAST_CH) && !r_mode) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next registered outputs; defaults are the idle values.
    always_comb begin
        w_a_nxt      = '0;
        w_enable_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_step_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_mode_nxt   = r_mode;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_enable_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_mode_nxt   = bus.mode;
                end
            end
            SCAN: begin
                if (!bus.stop) begin
                    if (w_advance && (r_a == LAST_CH) && !r_mode) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_enable_nxt = 1'b1;
                        w_busy_nxt   = 1'b1;
                        if (w_advance) begin
                            w_a_nxt    = r_a + SEL_W'(1);
                            w_step_nxt = 1'b1;
                        end else begin
                            w_a_nxt = r_a;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.a      = r_a;
    assign bus.enable = r_enable;
    assign bus.busy   = r_busy;
    assign bus.step   = r_step;
    assign bus.done   = r_done;

endmodule
